uart_tx: RTL
============

# uart_tx

UART transmitter, companion to the UART receiver in the same serial link. Accepts a parallel byte via a start strobe and serialises it as an 8N1 frame (start bit, 8 data bits LSB-first, one stop bit) on `tx`. Bit timing is derived from the same 16× oversampling tick scheme as the receiver, so both ends share one baud configuration.

## Interface
- `DATA_BITS`, 8: data bits per frame.
- `OVERSAMPLE`, 16: oversampling ticks per bit, matching the receiver's ticker.
- `BAUD_DIV`, 27: `sys_clk` cycles per oversampling tick; must be ≥ 1.

- `sys_clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `tx_start` in 1: request to send `data_in`; sampled only in IDLE.
- `data_in` in `DATA_BITS`: byte to send; latched on acceptance.
- `tx` out 1: serial line, idle high.
- `tx_busy` out 1: high from acceptance until return to IDLE.
- `tx_done` out 1: one-cycle pulse on frame completion.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE: `tx`=1, `tx_busy`=0. On `tx_start`=1, latch `data_in` into the shift register, clear the divider, tick counter and bit counter, then go to START.
- START: `tx`=0 for one bit period, then go to DATA.
- DATA: `tx`=shift_reg[0]. At the end of each bit period, shift right and increment the bit counter. After `DATA_BITS` periods, go to STOP.
- STOP: `tx`=1 for one bit period, then go to IDLE and pulse `tx_done`.
- Bit period = `BAUD_DIV`×`OVERSAMPLE` `sys_clk` cycles.
  - Divider counts 0..`BAUD_DIV`-1 and emits a tick on wrap.
  - Tick counter counts 0..`OVERSAMPLE`-1. A bit ends on the tick where the tick counter equals `OVERSAMPLE`-1.
- `tx_start` while not IDLE is ignored. Changing `data_in` after acceptance has no effect.
- `tx` is driven from a register, so no combinational glitches reach the line.
- Divider, tick counter and bit counter are held in reset while in IDLE.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, state=IDLE, all counters 0. Reset takes effect asynchronously, including mid-frame: `tx` goes high at once and the frame is abandoned.
- `tx_start` high at edge N (in IDLE): from cycle N+1, `tx`=0 and `tx_busy`=1.
- Frame length: (`DATA_BITS`+2)×`BAUD_DIV`×`OVERSAMPLE` cycles from the first low cycle to the first IDLE cycle.
- `tx_done`: high for exactly one cycle, the first IDLE cycle after STOP. `tx_busy`=0 in that same cycle.
- `tx_start` in the `tx_done` cycle is accepted. The next start bit begins one cycle later, so the stop bit is stretched by one cycle. This is the back-to-back throughput limit.
- `tx_start` held high continuously sends repeated frames, each separated by that one extra high cycle.
- Output latency to the line: one cycle (registered).

## Structure
- Shared package `uart_pkg`:
  - state encoding localparams (2-bit, IDLE=00, START=01, DATA=10, STOP=11);
  - `OVERSAMPLE`=16 default;
  - frame constants (start=0, stop=1).
- Reuse the team's `modulus_counter_parametrized` twice: the oversampling tick counter (final value `OVERSAMPLE`) and the bit counter (final value `DATA_BITS`).
- The divider and a parallel-load right-shift register stay inline in `uart_tx`.

## Test plan
- Reset: hold `reset_n`=0 → `tx`=1, `tx_busy`=0, `tx_done`=0. Release with `tx_start`=0 for 100 cycles → outputs unchanged.
- Single frame (`BAUD_DIV`=2, 32 cycles/bit): `data_in`=8'hA5 with a one-cycle `tx_start` → line shows 0,1,0,1,0,0,1,0,1,1, each held 32 cycles. `tx_done` pulses at cycle 321 after acceptance. `tx_busy` is high for 320 cycles.
- Busy ignore: send 8'h3C, then pulse `tx_start` with `data_in`=8'hFF at the midpoint of bit 3 → frame still carries 8'h3C. No second frame follows.
- Back-to-back: keep `tx_start`=1 and send 8'h00 then 8'hFF → second start bit begins exactly one cycle after the `tx_done` pulse. A loopback receiver recovers both bytes.
- Mid-frame reset: assert `reset_n`=0 during bit 5 of 8'h55 → `tx`=1 in the same cycle (async). After release, IDLE is reached and the next `tx_start` sends a clean full frame.
- Loopback: `tx` wired to the UART receiver `RX` with matching `BAUD_DIV`, 256 random bytes sent → all bytes match in order.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM encoding and counter width helper
//
// Purpose: constants common to the UART transmitter and receiver so both
// ends of the link agree on frame format and oversampling ratio.
// Ports: none (package).

package uart_pkg;

  // FSM state encoding (2-bit)
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] ST_DATA  = 2'b10;
  localparam logic [1:0] ST_STOP  = 2'b11;

  // Oversampling ticks per bit, shared with the receiver's ticker
  localparam int DEFAULT_OVERSAMPLE = 16;

  // Line levels of the framing bits
  localparam logic FRAME_START_BIT = 1'b0;
  localparam logic FRAME_STOP_BIT  = 1'b1;

  // Counter width for a modulus, never narrower than one bit
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - parallel-side handshake bundle of the UART transmitter
//
// Purpose: groups the byte request and the line/status outputs.
// Signals:
//   tx_start - request to send data_in (host -> transmitter)
//   data_in  - byte to send (host -> transmitter)
//   tx       - serial line, idle high (transmitter -> line)
//   tx_busy  - frame in progress (transmitter -> host)
//   tx_done  - one-cycle frame completion pulse (transmitter -> host)

interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] data_in;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_start,
    output data_in,
    input  tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  data_in,
    output tx,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/modulus_counter_parametrized.sv
// rtl/modulus_counter_parametrized.sv - enabled modulo-MODULUS up counter
//
// Purpose: counts 0..MODULUS-1 on each enable, wrapping to 0.
// Ports:
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low reset
//   clear   - synchronous clear, overrides en
//   en      - advance the count
//   count   - current value

module modulus_counter_parametrized
  import uart_pkg::*;
#(
  parameter int MODULUS = 16,
  parameter int WIDTH   = cnt_width(MODULUS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= (count == WIDTH'(MODULUS - 1)) ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with 16x oversampling bit timing
//
// Purpose: serialises a byte as start bit, DATA_BITS data bits LSB-first and
// one stop bit. One bit lasts BAUD_DIV * OVERSAMPLE sys_clk cycles.
// Ports:
//   sys_clk - clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - uart_tx_if slave: tx_start/data_in in, tx/tx_busy/tx_done out

module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int BAUD_DIV   = 27
) (
  input  logic     sys_clk,
  input  logic     reset_n,
  uart_tx_if.slave bus
);

  localparam int DIV_W  = cnt_width(BAUD_DIV);
  localparam int TICK_W = cnt_width(OVERSAMPLE);
  localparam int BIT_W  = cnt_width(DATA_BITS);

  logic [1:0]           state;
  logic [DIV_W-1:0]     div_cnt;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 in_idle;
  logic                 baud_tick;
  logic                 bit_end;
  logic                 last_bit;

  assign in_idle    = (state == ST_IDLE);
  assign baud_tick  = (div_cnt == DIV_W'(BAUD_DIV - 1));
  // A bit ends on the tick that completes the last oversampling slot
  assign bit_end    = baud_tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign last_bit   = (bit_cnt == BIT_W'(DATA_BITS - 1));
  assign shift_next = shift_reg >> 1;

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

  // Baud divider, parked at zero while idle so every frame starts aligned
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (in_idle || baud_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  modulus_counter_parametrized #(.MODULUS(OVERSAMPLE)) u_tick_cnt (
    .clk     (sys_clk),
    .reset_n (reset_n),
    .clear   (in_idle),
    .en      (baud_tick),
    .count   (tick_cnt)
  );

  modulus_counter_parametrized #(.MODULUS(DATA_BITS)) u_bit_cnt (
    .clk     (sys_clk),
    .reset_n (reset_n),
    .clear   (in_idle),
    .en      (bit_end && (state == ST_DATA)),
    .count   (bit_cnt)
  );

  // The line level is registered alongside each state change, so tx always
  // matches the state it belongs to without a combinational output path.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      tx_q      <= FRAME_STOP_BIT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.tx_start) begin
            shift_reg <= bus.data_in;
            tx_q      <= FRAME_START_BIT;
            busy_q    <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            tx_q  <= shift_reg[0];
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            shift_reg <= shift_next;
            if (last_bit) begin
              tx_q  <= FRAME_STOP_BIT;
              state <= ST_STOP;
            end else begin
              tx_q <= shift_next[0];
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: begin
          tx_q   <= FRAME_STOP_BIT;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
